// File: rtl/snake_game_ctrl.sv
// Game sequencer: RESTART/PLAY/DIE state machine, LFSR apple placement, score and speed tracking, death blink.
// Every output is registered. There is no backpressure: the snake logic samples add_cube and game_status as levels.
module snake_game_ctrl #(
  parameter int             CW           = 41,
  parameter logic [CW-1:0]  SPEED_BASE   = CW'(12_500_000),
  parameter logic [CW-1:0]  SPEED_STEP   = CW'(500_000),
  parameter logic [CW-1:0]  SPEED_MIN    = CW'(3_000_000),
  parameter int             FLASH_PERIOD = 12_500_000,
  parameter int             DIE_BLINKS   = 6,
  parameter logic [6:0]     APPLE_X0     = 7'd40,
  parameter logic [6:0]     APPLE_Y0     = 7'd30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_start,
  input  logic          hit_wall,
  input  logic          hit_body,
  input  logic [6:0]    head_x,
  input  logic [6:0]    head_y,
  output logic [1:0]    game_status,
  output logic          die_flash,
  output logic [CW-1:0] speed,
  output logic          add_cube,
  output logic [6:0]    apple_x,
  output logic [6:0]    apple_y,
  output logic [7:0]    score
);

  typedef enum logic [1:0] {
    S_RESTART = 2'b00,
    S_PLAY    = 2'b10,
    S_DIE     = 2'b11
  } state_t;

  localparam int FW = $clog2(FLASH_PERIOD + 1);
  localparam int BW = $clog2(DIE_BLINKS + 1);
  localparam logic [CW-1:0] SPEED_THRESH = SPEED_MIN + SPEED_STEP;

  state_t        state;
  logic [15:0]   lfsr;
  logic [FW-1:0] flash_cnt;
  logic [BW-1:0] blink_cnt;
  logic          seek;

  logic       lfsr_fb;
  logic [6:0] cand_x;
  logic [6:0] cand_y;
  logic       cand_ok;
  logic       head_on_apple;
  logic       collide;
  logic       blinks_done;

  assign lfsr_fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cand_x        = lfsr[6:0];
  assign cand_y        = {1'b0, lfsr[13:8]};
  assign cand_ok       = (cand_x >= 7'd1) && (cand_x <= 7'd75) &&
                         (cand_y >= 7'd1) && (cand_y <= 7'd58) &&
                         !((cand_x == head_x) && (cand_y == head_y));
  assign head_on_apple = (head_x == apple_x) && (head_y == apple_y);
  assign collide       = hit_wall | hit_body;
  assign blinks_done   = (blink_cnt == BW'(DIE_BLINKS));
  assign game_status   = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_RESTART;
      lfsr      <= 16'hACE1;
      flash_cnt <= '0;
      blink_cnt <= '0;
      seek      <= 1'b0;
      die_flash <= 1'b1;
      speed     <= SPEED_BASE;
      add_cube  <= 1'b0;
      apple_x   <= APPLE_X0;
      apple_y   <= APPLE_Y0;
      score     <= 8'd0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      case (state)
        S_RESTART: begin
          score     <= 8'd0;
          speed     <= SPEED_BASE;
          apple_x   <= APPLE_X0;
          apple_y   <= APPLE_Y0;
          die_flash <= 1'b1;
          add_cube  <= 1'b0;
          seek      <= 1'b0;
          if (key_start) state <= S_PLAY;
        end
        S_PLAY: begin
          // Collision outranks any apple activity in the same cycle.
          if (collide) begin
            state     <= S_DIE;
            add_cube  <= 1'b0;
            seek      <= 1'b0;
            flash_cnt <= '0;
            blink_cnt <= '0;
            die_flash <= 1'b1;
          end else if (seek) begin
            if (cand_ok) begin
              apple_x <= cand_x;
              apple_y <= cand_y;
              seek    <= 1'b0;
            end
          end else if (add_cube) begin
            add_cube <= 1'b0;
          end else if (head_on_apple) begin
            add_cube <= 1'b1;
            seek     <= 1'b1;
            score    <= (score == 8'hFF) ? score : score + 8'd1;
            speed    <= (speed >= SPEED_THRESH) ? speed - SPEED_STEP : SPEED_MIN;
          end
        end
        S_DIE: begin
          if (!blinks_done) begin
            if (flash_cnt == FW'(FLASH_PERIOD - 1)) begin
              flash_cnt <= '0;
              die_flash <= ~die_flash;
              blink_cnt <= blink_cnt + 1'b1;
            end else begin
              flash_cnt <= flash_cnt + 1'b1;
            end
          end else begin
            die_flash <= 1'b1;
            // Clear the game on the way out so RESTART is clean from its first cycle.
            if (key_start) begin
              state    <= S_RESTART;
              score    <= 8'd0;
              speed    <= SPEED_BASE;
              apple_x  <= APPLE_X0;
              apple_y  <= APPLE_Y0;
              add_cube <= 1'b0;
            end
          end
        end
        default: state <= S_RESTART;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: stimulus queues expectations, a negedge monitor pops and compares.
module tb_snake_game_ctrl;

  localparam logic [40:0] BASE = 41'd12_500_000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_start = 1'b0;
  logic        hit_wall = 1'b0;
  logic        hit_body = 1'b0;
  logic [6:0]  head_x = 7'd0;
  logic [6:0]  head_y = 7'd0;
  logic [1:0]  game_status;
  logic        die_flash;
  logic [40:0] speed;
  logic        add_cube;
  logic [6:0]  apple_x;
  logic [6:0]  apple_y;
  logic [7:0]  score;

  snake_game_ctrl #(.FLASH_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .hit_wall(hit_wall), .hit_body(hit_body),
    .head_x(head_x), .head_y(head_y), .game_status(game_status), .die_flash(die_flash),
    .speed(speed), .add_cube(add_cube), .apple_x(apple_x), .apple_y(apple_y), .score(score)
  );

  always #5 clk = ~clk;

  // kind: 0 = full snapshot, 1 = expired wait, 2 = grow queue must be drained
  typedef struct {
    int          kind;
    string       name;
    logic [1:0]  st;
    logic        fl;
    logic [40:0] spd;
    logic        add;
    logic        chk_ap;
    logic [6:0]  ax;
    logic [6:0]  ay;
    logic [7:0]  sc;
  } snap_t;

  typedef struct {
    logic [7:0]  sc;
    logic [40:0] spd;
  } grow_t;

  snap_t snap_q[$];
  grow_t grow_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic logic [40:0] exp_speed(int k);
    longint v;
    v = 64'd12_500_000 - longint'(k) * 500_000;
    if (v < 3_000_000) v = 3_000_000;
    return 41'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input string name, input logic [1:0] st, input logic fl, input logic [40:0] spd,
                      input logic add, input logic chk_ap, input logic [6:0] ax, input logic [6:0] ay,
                      input logic [7:0] sc);
    snap_t s;
    s.kind = 0; s.name = name; s.st = st; s.fl = fl; s.spd = spd; s.add = add;
    s.chk_ap = chk_ap; s.ax = ax; s.ay = ay; s.sc = sc;
    snap_q.push_back(s);
  endtask

  task automatic flag(input int kind, input string name);
    snap_t s;
    s = '{kind: kind, name: name, st: 2'b00, fl: 1'b0, spd: '0, add: 1'b0, chk_ap: 1'b0,
          ax: 7'd0, ay: 7'd0, sc: 8'd0};
    snap_q.push_back(s);
  endtask

  task automatic expect_grow(input int k);
    grow_t g;
    g.sc = 8'(k);
    g.spd = exp_speed(k);
    grow_q.push_back(g);
  endtask

  task automatic wait_fall(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (!add_cube) done = 1'b1;
    end
    if (!done) flag(1, name);
  endtask

  // Monitor: the only process that compares and counts.
  logic       prev_add = 1'b0;
  logic [6:0] prev_ax = 7'd40;
  logic [6:0] prev_ay = 7'd30;
  logic       pend_fall = 1'b0;

  always @(negedge clk) begin
    if (pend_fall) begin
      checks++;
      if (add_cube !== 1'b0) begin
        errors++;
        $display("FAIL add_fall: add_cube=%b, want 0 one cycle after apple move", add_cube);
      end
      pend_fall = 1'b0;
    end
    if (game_status == 2'b10 && (apple_x != prev_ax || apple_y != prev_ay)) begin
      checks++;
      if (!(apple_x >= 1 && apple_x <= 75 && apple_y >= 1 && apple_y <= 58) ||
          (apple_x == head_x && apple_y == head_y)) begin
        errors++;
        $display("FAIL apple_place: apple=(%0d,%0d) head=(%0d,%0d), want x 1..75, y 1..58, not head",
                 apple_x, apple_y, head_x, head_y);
      end
      pend_fall = 1'b1;
    end
    if (add_cube && !prev_add) begin
      checks++;
      if (grow_q.size() == 0) begin
        errors++;
        $display("FAIL grow_unexpected: add_cube rose with score=%0d, want no grow", score);
      end else begin
        grow_t g;
        g = grow_q.pop_front();
        if (score !== g.sc || speed !== g.spd) begin
          errors++;
          $display("FAIL grow: score=%0d speed=%0d, want score=%0d speed=%0d", score, speed, g.sc, g.spd);
        end
      end
    end
    if (snap_q.size() != 0) begin
      snap_t s;
      s = snap_q.pop_front();
      checks++;
      if (s.kind == 1) begin
        errors++;
        $display("FAIL %s: wait expired, want event within budget", s.name);
      end else if (s.kind == 2) begin
        if (grow_q.size() != 0) begin
          errors++;
          $display("FAIL %s: %0d grow events pending, want 0", s.name, grow_q.size());
        end
      end else if (game_status !== s.st || die_flash !== s.fl || speed !== s.spd ||
                   add_cube !== s.add || score !== s.sc ||
                   (s.chk_ap && (apple_x !== s.ax || apple_y !== s.ay))) begin
        errors++;
        $display("FAIL %s: got st=%b fl=%b spd=%0d add=%b apple=(%0d,%0d) score=%0d, want st=%b fl=%b spd=%0d add=%b apple=(%0d,%0d)%s score=%0d",
                 s.name, game_status, die_flash, speed, add_cube, apple_x, apple_y, score,
                 s.st, s.fl, s.spd, s.add, s.ax, s.ay, s.chk_ap ? "" : "(any)", s.sc);
      end
    end
    prev_add = add_cube;
    prev_ax  = apple_x;
    prev_ay  = apple_y;
  end

  initial begin
    int toggles;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    snap("reset_idle", 2'b00, 1'b1, BASE, 1'b0, 1'b1, 7'd40, 7'd30, 8'd0);

    key_start = 1'b1; tick(); key_start = 1'b0;
    snap("start", 2'b10, 1'b1, BASE, 1'b0, 1'b1, 7'd40, 7'd30, 8'd0);

    head_x = 7'd40; head_y = 7'd30;
    expect_grow(1);
    tick();
    snap("hit1", 2'b10, 1'b1, 41'd12_000_000, 1'b1, 1'b1, 7'd40, 7'd30, 8'd1);
    wait_fall("fall1");

    for (int k = 2; k <= 20; k++) begin
      head_x = apple_x; head_y = apple_y;
      expect_grow(k);
      tick();
      wait_fall("fall_loop");
    end
    snap("score20", 2'b10, 1'b1, 41'd3_000_000, 1'b0, 1'b0, 7'd0, 7'd0, 8'd20);

    // Collision and apple in the same cycle
    head_x = apple_x; head_y = apple_y; hit_body = 1'b1;
    tick();
    hit_body = 1'b0;
    snap("die_entry", 2'b11, 1'b1, 41'd3_000_000, 1'b0, 1'b0, 7'd0, 7'd0, 8'd20);
    for (int k = 1; k <= 30; k++) begin
      if (k == 10) key_start = 1'b1;
      if (k == 11) key_start = 1'b0;
      tick();
      toggles = (k / 4 > 6) ? 6 : k / 4;
      snap("blink", 2'b11, (toggles % 2) == 0, 41'd3_000_000, 1'b0, 1'b0, 7'd0, 7'd0, 8'd20);
    end

    key_start = 1'b1; tick(); key_start = 1'b0;
    snap("restart", 2'b00, 1'b1, BASE, 1'b0, 1'b1, 7'd40, 7'd30, 8'd0);

    // Reset while seeking
    key_start = 1'b1; tick(); key_start = 1'b0;
    head_x = 7'd40; head_y = 7'd30;
    expect_grow(1);
    tick();
    rst = 1'b0;
    tick();
    snap("rst_seek", 2'b00, 1'b1, BASE, 1'b0, 1'b1, 7'd40, 7'd30, 8'd0);
    rst = 1'b1;

    // Glitch on rst between edges
    head_x = 7'd0; head_y = 7'd0;
    key_start = 1'b1; tick(); key_start = 1'b0;
    rst = 1'b0; #2; rst = 1'b1;
    tick();
    snap("glitch", 2'b10, 1'b1, BASE, 1'b0, 1'b1, 7'd40, 7'd30, 8'd0);

    // Reset while blinking
    hit_wall = 1'b1; tick(); hit_wall = 1'b0;
    snap("die2", 2'b11, 1'b1, BASE, 1'b0, 1'b1, 7'd40, 7'd30, 8'd0);
    repeat (5) tick();
    snap("die2_blink", 2'b11, 1'b0, BASE, 1'b0, 1'b1, 7'd40, 7'd30, 8'd0);
    rst = 1'b0; tick(); rst = 1'b1;
    snap("rst_die", 2'b00, 1'b1, BASE, 1'b0, 1'b1, 7'd40, 7'd30, 8'd0);

    // key_start coincident with collision in PLAY
    key_start = 1'b1; tick(); key_start = 1'b0;
    key_start = 1'b1; hit_wall = 1'b1; tick(); key_start = 1'b0; hit_wall = 1'b0;
    snap("key_and_hit", 2'b11, 1'b1, BASE, 1'b0, 1'b1, 7'd40, 7'd30, 8'd0);

    tick();
    flag(2, "grow_drained");
    for (int i = 0; i < 50 && snap_q.size() != 0; i++) tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Top-level game sequencer for the snake datapath.
- Owns the game state machine (RESTART/PLAY/DIE) and drives `game_status` to the snake body logic.
- Places the apple with an LFSR and raises `add_cube` when the head reaches it.
- Counts score, shortens the move period (`speed`) as score rises, and generates the death-blink `die_flash`.

Parameters:
- CW, 41, width of `speed` output.
- SPEED_BASE, 12_500_000, initial move period in clk cycles.
- SPEED_STEP, 500_000, period reduction per apple eaten.
- SPEED_MIN, 3_000_000, floor for the move period.
- FLASH_PERIOD, 12_500_000, clk cycles per `die_flash` half-period.
- DIE_BLINKS, 6, number of `die_flash` toggles after death.
- APPLE_X0, 40, apple x after reset/restart (grid units).
- APPLE_Y0, 30, apple y after reset/restart (grid units).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- key_start  in  1  one-cycle pulse: start/restart request
- hit_wall  in  1  level, wall/obstacle collision from snake logic
- hit_body  in  1  level, self-collision from snake logic
- head_x  in  7  head x (grid units)
- head_y  in  7  head y (grid units)
- game_status  out  2  00 RESTART, 10 PLAY, 11 DIE
- die_flash  out  1  1 = snake visible, 0 = blanked
- speed  out  CW  current move period
- add_cube  out  1  grow request, level
- apple_x  out  7  apple x
- apple_y  out  7  apple y
- score  out  8  apples eaten, saturating

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-low. All state updates on posedge clk.
- Reset values, applied whenever `rst`=0 at a clock edge:
  - game_status=00, die_flash=1, speed=SPEED_BASE, add_cube=0
  - apple=(APPLE_X0,APPLE_Y0), score=0, lfsr=16'hACE1
  - flash counter=0, blink count=0
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state except reset.
- FSM:
  - RESTART: on key_start -> PLAY. Otherwise holds. While here, score=0, speed=SPEED_BASE, apple=(APPLE_X0,APPLE_Y0), die_flash=1, add_cube=0.
  - PLAY: on (hit_wall|hit_body) -> DIE. key_start is ignored.
  - DIE: flash counter counts 0..FLASH_PERIOD-1; at wrap, die_flash toggles and blink count increments. After DIE_BLINKS toggles, die_flash is forced to 1 and stays there. key_start -> RESTART is accepted only after blinking completes; earlier pulses are dropped. On entry to DIE, the flash counter and blink count clear and add_cube drops to 0.
- Apple/grow (PLAY only):
  - add_cube is registered: asserts 1 cycle after head==apple, and stays high while head==apple and apple is unchanged.
  - On the cycle add_cube rises: score increments, saturating at 255.
  - Same cycle: speed <= speed-SPEED_STEP if that result is >= SPEED_MIN, else SPEED_MIN.
  - Same cycle: the SEEK sub-state is entered.
  - SEEK: each cycle, candidate x=lfsr[6:0], y=lfsr[13:8]. Accept if 1<=x<=75 and 1<=y<=58, and candidate != current head. On accept, apple updates and SEEK exits. Otherwise retry next cycle.
  - add_cube falls the cycle after the apple moves.
  - No body-overlap check on placement.
- Simultaneous events:
  - Collision and apple hit in the same cycle: DIE wins, with no score or speed change.
  - Reset mid-SEEK or mid-DIE: reset values, no residue.
  - key_start coincident with collision in PLAY: DIE.
- speed changes only at apple events or restart, never mid-DIE.

Test Plan:
- Reset, then 3 idle cycles -> status=00, die_flash=1, speed=12_500_000, apple=(40,30), score=0.
- key_start pulse, then head=(40,30) -> add_cube=1 one cycle later; score=1; speed=12_000_000; apple moves within 1..75/1..58 and != (40,30); add_cube=0 the cycle after the move.
- Force 20 apple hits -> score=20; speed clamps at 3_000_000 from hit 19 onward.
- hit_body=1 and head==apple in the same PLAY cycle -> status=11, score unchanged, add_cube=0. With FLASH_PERIOD=4, die_flash toggles every 4 cycles for 6 toggles, then holds at 1.
- key_start during blinking -> ignored. key_start after blinking -> status=00, score=0, speed=SPEED_BASE, apple=(40,30).
- rst=0 asserted during SEEK and during DIE -> all outputs at reset values on the next edge; asynchronous glitch on rst between edges -> no effect.
